// File: rtl/fcw_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fcw_sequencer_if
//  Brief    : Port bundle between the FCW sequencer and the 4 x 24-bit FCW RAM
//  Revision : 1.0  initial release
// ============================================================================
interface fcw_sequencer_if;
  logic        ram_rd_en;
  logic        ram_wr_en;
  logic [1:0]  ram_addr;
  logic [23:0] ram_wd;
  logic [23:0] ram_rd_data;

  modport master (
    output ram_rd_en,
    output ram_wr_en,
    output ram_addr,
    output ram_wd,
    input  ram_rd_data
  );

  modport slave (
    input  ram_rd_en,
    input  ram_wr_en,
    input  ram_addr,
    input  ram_wd,
    output ram_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/fcw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fcw_sequencer
//  Brief    : Steps through four FCW RAM entries, holds each on the NCO input,
//             and applies saturating live edits to the playing entry.
//  Revision : 1.0  initial release
// ============================================================================
module fcw_sequencer #(
  parameter int          CYCLES_PER_NOTE = 25000000,
  parameter logic [23:0] FCW_STEP        = 24'h000100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_pause,
  input  logic                  edit_inc,
  input  logic                  edit_dec,
  fcw_sequencer_if.master       ram,
  output logic [23:0]           fcw,
  output logic                  fcw_valid,
  output logic [1:0]            note_idx,
  output logic                  playing
);

  localparam int c_TIMER_W = (CYCLES_PER_NOTE > 1) ? $clog2(CYCLES_PER_NOTE) : 1;
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(CYCLES_PER_NOTE - 1);
  localparam logic [23:0] c_FCW_MAX = 24'hFFFFFF;

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_LATCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_EDIT_WR = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [1:0]             r_note_idx;
  logic [1:0]             w_note_next;
  logic [c_TIMER_W-1:0]   r_timer;
  logic [c_TIMER_W-1:0]   w_timer_next;
  logic                   r_playing;
  logic [23:0]            r_fcw;
  logic                   r_fcw_valid;
  logic                   r_ram_rd_en;
  logic                   r_ram_wr_en;
  logic [1:0]             r_ram_addr;
  logic [23:0]            r_ram_wd;
  logic [23:0]            w_wd_next;
  logic                   w_edit;
  logic [24:0]            w_sum;
  logic [24:0]            w_diff;
  logic [23:0]            w_edit_val;

  // Carry/borrow out of the 25-bit results selects the saturated value.
  assign w_edit  = edit_inc ^ edit_dec;
  assign w_sum   = {1'b0, r_fcw} + {1'b0, FCW_STEP};
  assign w_diff  = {1'b0, r_fcw} - {1'b0, FCW_STEP};
  assign w_edit_val = edit_inc ? (w_sum[24]  ? c_FCW_MAX : w_sum[23:0])
                               : (w_diff[24] ? 24'h000000 : w_diff[23:0]);

  always_comb begin
    w_next_state = r_state;
    w_note_next  = r_note_idx;
    w_timer_next = r_timer;
    w_wd_next    = r_ram_wd;
    case (r_state)
      // Straight out of reset the read strobe is not yet registered, so
      // LOAD waits one cycle to issue it before moving on.
      S_LOAD: begin
        if (r_ram_rd_en) begin
          w_next_state = S_LATCH;
        end
      end
      S_LATCH: begin
        w_next_state = S_HOLD;
        w_timer_next = '0;
      end
      S_HOLD: begin
        if (w_edit) begin
          w_next_state = S_EDIT_WR;
          w_wd_next    = w_edit_val;
        end else if (r_playing) begin
          if (r_timer == c_TIMER_LAST) begin
            w_next_state = S_LOAD;
            w_note_next  = r_note_idx + 2'd1;
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
      end
      S_EDIT_WR: begin
        w_next_state = S_LOAD;
      end
      default: begin
        w_next_state = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_note_idx  <= 2'd0;
      r_timer     <= '0;
      r_playing   <= 1'b0;
      r_fcw       <= 24'h000000;
      r_fcw_valid <= 1'b0;
      r_ram_rd_en <= 1'b0;
      r_ram_wr_en <= 1'b0;
      r_ram_addr  <= 2'd0;
      r_ram_wd    <= 24'h000000;
    end else begin
      r_state     <= w_next_state;
      r_note_idx  <= w_note_next;
      r_timer     <= w_timer_next;
      r_playing   <= r_playing ^ play_pause;
      r_ram_wd    <= w_wd_next;
      // RAM strobes are registered from the next state so they line up with it.
      r_ram_rd_en <= (w_next_state == S_LOAD);
      r_ram_wr_en <= (w_next_state == S_EDIT_WR);
      if ((w_next_state == S_LOAD) || (w_next_state == S_EDIT_WR)) begin
        r_ram_addr <= w_note_next;
      end
      if (r_state == S_LATCH) begin
        r_fcw       <= ram.ram_rd_data;
        r_fcw_valid <= 1'b1;
      end
    end
  end

  assign ram.ram_rd_en = r_ram_rd_en;
  assign ram.ram_wr_en = r_ram_wr_en;
  assign ram.ram_addr  = r_ram_addr;
  assign ram.ram_wd    = r_ram_wd;
  assign fcw           = r_fcw;
  assign fcw_valid     = r_fcw_valid;
  assign note_idx      = r_note_idx;
  assign playing       = r_playing;

endmodule
`default_nettype wire

// File: tb/tb_fcw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fcw_sequencer
//  Brief    : Directed and randomized bench for fcw_sequencer with RAM models
//  Revision : 1.0  initial release
// ============================================================================
module tb_fcw_sequencer;
  localparam int          C      = 4;
  localparam logic [23:0] STEP_A = 24'h000100;
  localparam logic [23:0] STEP_B = 24'h800000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pp, inc, dec;
  logic        b_pp, b_inc, b_dec;
  logic [23:0] a_fcw, b_fcw;
  logic        a_valid, b_valid;
  logic [1:0]  a_note, b_note;
  logic        a_play, b_play;
  int          checks = 0;
  int          failures = 0;

  fcw_sequencer_if a_bus ();
  fcw_sequencer_if b_bus ();

  always #5 clk = ~clk;

  fcw_sequencer #(.CYCLES_PER_NOTE(C), .FCW_STEP(STEP_A)) dut_a (
    .clk(clk), .rst(rst), .play_pause(pp), .edit_inc(inc), .edit_dec(dec),
    .ram(a_bus), .fcw(a_fcw), .fcw_valid(a_valid), .note_idx(a_note), .playing(a_play)
  );

  fcw_sequencer #(.CYCLES_PER_NOTE(C), .FCW_STEP(STEP_B)) dut_b (
    .clk(clk), .rst(rst), .play_pause(b_pp), .edit_inc(b_inc), .edit_dec(b_dec),
    .ram(b_bus), .fcw(b_fcw), .fcw_valid(b_valid), .note_idx(b_note), .playing(b_play)
  );

  function automatic logic [23:0] init_word(input int i);
    case (i)
      0:       return 24'h00EC3C;
      1:       return 24'h010905;
      2:       return 24'h01194B;
      default: return 24'h013BCD;
    endcase
  endfunction

  // RAM models: reset restores contents and beats any write in flight.
  logic [23:0] mem_a [4];
  logic [23:0] mem_b [4];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_a[i] <= init_word(i);
    end else begin
      if (a_bus.ram_wr_en) mem_a[a_bus.ram_addr] <= a_bus.ram_wd;
      if (a_bus.ram_rd_en) a_bus.ram_rd_data <= mem_a[a_bus.ram_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_b[i] <= init_word(i);
    end else begin
      if (b_bus.ram_wr_en) mem_b[b_bus.ram_addr] <= b_bus.ram_wd;
      if (b_bus.ram_rd_en) b_bus.ram_rd_data <= mem_b[b_bus.ram_addr];
    end
  end

  // Reference model: m_gap counts edges until the next fcw takes effect (0 = holding).
  logic [23:0] m_mem [4];
  logic [1:0]  m_note;
  logic        m_play, m_valid, m_wr;
  logic [23:0] m_fcw, m_wd;
  logic [1:0]  m_waddr;
  int          m_gap, m_held;

  function automatic logic [23:0] sat_add(input logic [23:0] v, input logic [23:0] s);
    int t;
    t = $signed({8'd0, v}) + $signed({8'd0, s});
    return (t > 32'h00FFFFFF) ? 24'hFFFFFF : t[23:0];
  endfunction

  function automatic logic [23:0] sat_sub(input logic [23:0] v, input logic [23:0] s);
    int t;
    t = $signed({8'd0, v}) - $signed({8'd0, s});
    return (t < 0) ? 24'h000000 : t[23:0];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = init_word(i);
    m_note = 2'd0; m_play = 1'b0; m_valid = 1'b0; m_wr = 1'b0;
    m_fcw = 24'h0; m_wd = 24'h0; m_waddr = 2'd0;
    m_gap = 3; m_held = 0;
  endtask

  task automatic m_step(input logic p, input logic i, input logic d);
    m_wr = 1'b0;
    if (m_gap == 0) begin
      if (i ^ d) begin
        m_wd = i ? sat_add(m_fcw, STEP_A) : sat_sub(m_fcw, STEP_A);
        m_mem[m_note] = m_wd;
        m_waddr = m_note;
        m_wr = 1'b1;
        m_gap = 3;
      end else if (m_play) begin
        if (m_held == C - 1) begin
          m_note = m_note + 2'd1;
          m_gap = 2;
        end else begin
          m_held++;
        end
      end
    end else begin
      m_gap--;
      if (m_gap == 0) begin
        m_fcw = m_mem[m_note];
        m_valid = 1'b1;
        m_held = 0;
      end
    end
    m_play = m_play ^ p;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("fcw", a_fcw, m_fcw);
    check("fcw_valid", a_valid, m_valid);
    check("note_idx", a_note, m_note);
    check("playing", a_play, m_play);
    check("wr_en", a_bus.ram_wr_en, m_wr);
    if (m_wr) begin
      check("wr_addr", a_bus.ram_addr, m_waddr);
      check("wr_data", a_bus.ram_wd, m_wd);
    end
    check("rd_en", a_bus.ram_rd_en, (m_gap == 2));
    if (m_gap == 2) check("rd_addr", a_bus.ram_addr, m_note);
    check("rd_wr_excl", a_bus.ram_rd_en & a_bus.ram_wr_en, 1'b0);
    check("b_rd_wr_excl", b_bus.ram_rd_en & b_bus.ram_wr_en, 1'b0);
  endtask

  task automatic cycle(input logic p, input logic i, input logic d);
    pp = p; inc = i; dec = d;
    @(posedge clk);
    m_step(p, i, d);
    @(negedge clk);
    pp = 1'b0; inc = 1'b0; dec = 1'b0;
    b_pp = 1'b0; b_inc = 1'b0; b_dec = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pp = 1'b0; inc = 1'b0; dec = 1'b0;
    b_pp = 1'b0; b_inc = 1'b0; b_dec = 1'b0;
    @(posedge clk);
    m_reset();
    @(negedge clk);
    check_all();
    check("rst_b_fcw", b_fcw, 24'h0);
    check("rst_b_valid", b_valid, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] prev, seen [$];
    int          stamp [$];
    int          cyc;
    logic        ok;
    logic [1:0]  n;
    logic        p, i, d;

    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Read of entry 0 straight after reset, then fcw two cycles later.
    cycle(0, 0, 0);
    check("boot_rd_en", a_bus.ram_rd_en, 1'b1);
    check("boot_rd_addr", a_bus.ram_addr, 2'd0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("boot_fcw", a_fcw, 24'h00EC3C);
    check("boot_valid", a_valid, 1'b1);
    repeat (50) cycle(0, 0, 0);
    check("idle_fcw", a_fcw, 24'h00EC3C);
    check("idle_note", a_note, 2'd0);

    // One playback lap: record every fcw change and when it happened.
    cycle(1, 0, 0);
    prev = a_fcw;
    cyc = 0;
    while (seen.size() < 4 && cyc < 60) begin
      cycle(0, 0, 0);
      cyc++;
      if (a_fcw !== prev) begin
        seen.push_back(a_fcw);
        stamp.push_back(cyc);
        prev = a_fcw;
      end
    end
    check("lap_len", seen.size(), 4);
    if (seen.size() == 4) begin
      check("lap_fcw1", seen[0], 24'h010905);
      check("lap_fcw2", seen[1], 24'h01194B);
      check("lap_fcw3", seen[2], 24'h013BCD);
      check("lap_fcw0", seen[3], 24'h00EC3C);
      check("lap_period12", stamp[1] - stamp[0], C + 2);
      check("lap_period23", stamp[2] - stamp[1], C + 2);
      check("lap_period30", stamp[3] - stamp[2], C + 2);
    end
    check("lap_wrap_note", a_note, 2'd0);

    // Pause at timer 2 of note 1.
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (m_note == 2'd1 && m_gap == 0 && m_held == 2) ok = 1'b1;
      else cycle(0, 0, 0);
    end
    check("pause_reach", ok, 1'b1);
    cycle(1, 0, 0);
    repeat (20) cycle(0, 0, 0);
    check("pause_fcw", a_fcw, 24'h010905);
    check("pause_note", a_note, 2'd1);

    // Edit while paused on note 1.
    cycle(0, 1, 0);
    check("edit_wr_en", a_bus.ram_wr_en, 1'b1);
    check("edit_addr", a_bus.ram_addr, 2'd1);
    check("edit_wd", a_bus.ram_wd, 24'h010A05);
    repeat (3) cycle(0, 0, 0);
    check("edit_fcw", a_fcw, 24'h010A05);

    // Resume and come back round to note 1.
    cycle(1, 0, 0);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      cycle(0, 0, 0);
      if (m_note == 2'd2) ok = 1'b1;
    end
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      cycle(0, 0, 0);
      if (m_note == 2'd1 && m_gap == 0) ok = 1'b1;
    end
    check("relap_reach", ok, 1'b1);
    check("relap_fcw", a_fcw, 24'h010A05);

    // Both edit pulses together: no write.
    cycle(0, 1, 1);
    check("both_no_wr", a_bus.ram_wr_en, 1'b0);

    // Edit on the last hold cycle beats the advance.
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (m_gap == 0 && m_play && m_held == C - 1) ok = 1'b1;
      else cycle(0, 0, 0);
    end
    check("expiry_reach", ok, 1'b1);
    n = a_note;
    cycle(0, 0, 1);
    check("expiry_wr_en", a_bus.ram_wr_en, 1'b1);
    check("expiry_note", a_note, n);

    // Reset while the write strobe is up.
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (m_gap == 0 && m_note == 2'd1) ok = 1'b1;
      else cycle(0, 0, 0);
    end
    check("rstwr_reach", ok, 1'b1);
    cycle(0, 1, 0);
    check("rstwr_pending", a_bus.ram_wr_en, 1'b1);
    do_reset();
    check("rstwr_wr_en", a_bus.ram_wr_en, 1'b0);
    cycle(1, 0, 0);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      cycle(0, 0, 0);
      if (m_note == 2'd1 && m_gap == 0) ok = 1'b1;
    end
    check("rstwr_reach1", ok, 1'b1);
    check("rstwr_fcw1", a_fcw, 24'h010905);

    // Randomized pulses against the model.
    for (int k = 0; k < 400; k++) begin
      p = ($urandom_range(0, 15) == 0);
      i = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 9) == 0);
      cycle(p, i, d);
    end

    // Saturation on the large-step instance.
    do_reset();
    repeat (3) cycle(0, 0, 0);
    check("sat_boot", b_fcw, 24'h00EC3C);
    b_dec = 1'b1;
    cycle(0, 0, 0);
    check("sat_dec_wr", b_bus.ram_wr_en, 1'b1);
    check("sat_dec_addr", b_bus.ram_addr, 2'd0);
    check("sat_dec_wd", b_bus.ram_wd, 24'h000000);
    b_pp = 1'b1;
    cycle(0, 0, 0);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      cycle(0, 0, 0);
      if (b_note == 2'd3 && b_fcw == 24'h013BCD) ok = 1'b1;
    end
    check("sat_reach3", ok, 1'b1);
    b_pp = 1'b1;
    cycle(0, 0, 0);
    b_inc = 1'b1;
    cycle(0, 0, 0);
    check("sat_inc1_wr", b_bus.ram_wr_en, 1'b1);
    check("sat_inc1_addr", b_bus.ram_addr, 2'd3);
    check("sat_inc1_wd", b_bus.ram_wd, 24'h813BCD);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      cycle(0, 0, 0);
      if (b_fcw == 24'h813BCD) ok = 1'b1;
    end
    check("sat_reload", ok, 1'b1);
    b_inc = 1'b1;
    cycle(0, 0, 0);
    check("sat_inc2_wr", b_bus.ram_wr_en, 1'b1);
    check("sat_inc2_wd", b_bus.ram_wd, 24'hFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
